spi_op_slave: RTL

SPI_OP_SLAVE -- requirements
Module: spi_op_slave

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_if.sv | 12 +
 rtl/spi_edge_sync.sv | 77 +++++++
 rtl/spi_op_slave.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and default sizing for the SPI operand slaves.
package spi_pkg;

   localparam int DEF_OP_WIDTH   = 4;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_WAIT_EDGES = 9;

   // Word sent back when the core never delivered a result in time
   localparam logic [31:0] LATE_WORD = 32'hDEAD_BEEF;

   typedef enum logic [2:0] {
      IDLE,
      RX_OP,
      RX_A,
      RX_B,
      WAIT,
      TX_RES,
      DONE
   } spi_slave_state_t;

endpackage

// File: rtl/spi_if.sv
// spi_if: four-wire SPI bundle (sclk idles low, nss active low).
interface spi_if;

   logic sclk;
   logic mosi;
   logic nss;
   logic miso;

   modport SLAVE  (input sclk, input mosi, input nss, output miso);
   modport MASTER (output sclk, output mosi, output nss, input miso);

endinterface

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: brings sclk/mosi/nss into the clock domain through two flops
// and reports sclk rise/fall and nss fall as single-cycle pulses.
module spi_edge_sync (
   input  logic clock,
   input  logic reset,
   input  logic sclk_in,
   input  logic mosi_in,
   input  logic nss_in,
   output logic mosi,
   output logic nss,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic nss_fall
);

   // Bit order {nss, mosi, sclk}; the bus idles with nss high, sclk/mosi low
   localparam logic [2:0] IDLE_LEVELS = 3'b100;

   logic [2:0] raw_bits;
   logic [2:0] sync_bits;
   logic       sclk_prev_reg;
   logic       nss_prev_reg;
   logic [1:0] settle_reg;
   logic       settled;

   assign raw_bits = {nss_in, mosi_in, sclk_in};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_sync
         logic meta_reg;
         logic sync_reg;

         // Two-flop synchronizer for one SPI pin
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               meta_reg <= IDLE_LEVELS[gi];
               sync_reg <= IDLE_LEVELS[gi];
            end else begin
               meta_reg <= raw_bits[gi];
               sync_reg <= meta_reg;
            end
         end

         assign sync_bits[gi] = sync_reg;
      end
   endgenerate

   // Previous synchronized levels for edge detection
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sclk_prev_reg <= 1'b0;
         nss_prev_reg  <= 1'b1;
      end else begin
         sclk_prev_reg <= sync_bits[0];
         nss_prev_reg  <= sync_bits[2];
      end
   end

   // Edges are masked until the chain has refilled with real pin levels, so a
   // reset released while nss is already low does not look like a new frame
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         settle_reg <= 2'd0;
      end else if (settle_reg != 2'd3) begin
         settle_reg <= settle_reg + 2'd1;
      end
   end

   assign settled   = (settle_reg == 2'd3);
   assign mosi      = sync_bits[1];
   assign nss       = sync_bits[2];
   assign sclk_rise = settled &  sync_bits[0] & ~sclk_prev_reg;
   assign sclk_fall = settled & ~sync_bits[0] &  sclk_prev_reg;
   assign nss_fall  = settled & ~sync_bits[2] &  nss_prev_reg;

endmodule

// File: rtl/spi_op_slave.sv
// spi_op_slave: SPI slave that receives opcode + two operands, hands them to a
// core, waits a fixed number of SCLK edges and shifts the core result back.
// Optional feature macro: SPI_OP_SLAVE_LATE_EN (late result -> DEADBEEF + late_err).
module spi_op_slave
   import spi_pkg::*;
#(
   parameter int OP_WIDTH   = DEF_OP_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int WAIT_EDGES = DEF_WAIT_EDGES
) (
   input  logic                  clock,
   input  logic                  reset,
   spi_if.SLAVE                  spi,
   output logic                  op_valid,
   output logic [OP_WIDTH-1:0]   op,
   output logic [DATA_WIDTH-1:0] a,
   output logic [DATA_WIDTH-1:0] b,
   input  logic                  res_valid,
   input  logic [DATA_WIDTH-1:0] res
`ifdef SPI_OP_SLAVE_LATE_EN
   ,
   output logic                  late_err
`endif
);

   localparam int CNT_MAX = (DATA_WIDTH > WAIT_EDGES) ? DATA_WIDTH : WAIT_EDGES;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;

   localparam logic [CNT_W-1:0] OP_LAST   = CNT_W'(OP_WIDTH - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_EDGES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

`ifdef SPI_OP_SLAVE_LATE_EN
   localparam logic [DATA_WIDTH-1:0] MISSING_WORD = DATA_WIDTH'(LATE_WORD);
`else
   localparam logic [DATA_WIDTH-1:0] MISSING_WORD = '0;
`endif

   logic mosi_s;
   logic nss_s;
   logic sclk_rise;
   logic sclk_fall;
   logic nss_fall;

   spi_slave_state_t      state_reg;
   logic [CNT_W-1:0]      bit_cnt_reg;
   logic [DATA_WIDTH-1:0] rx_shift_reg;
   logic [OP_WIDTH-1:0]   op_hold_reg;
   logic [DATA_WIDTH-1:0] a_hold_reg;
   logic [OP_WIDTH-1:0]   op_reg;
   logic [DATA_WIDTH-1:0] a_reg;
   logic [DATA_WIDTH-1:0] b_reg;
   logic                  op_valid_reg;
   logic [DATA_WIDTH-1:0] result_reg;
   logic                  res_seen_reg;
   logic [DATA_WIDTH-1:0] tx_shift_reg;
   logic                  miso_reg;
`ifdef SPI_OP_SLAVE_LATE_EN
   logic                  late_err_reg;
`endif

   logic [DATA_WIDTH-1:0] rx_next;
   logic [DATA_WIDTH-1:0] tx_word;

   spi_edge_sync u_sync (
      .clock     (clock),
      .reset     (reset),
      .sclk_in   (spi.sclk),
      .mosi_in   (spi.mosi),
      .nss_in    (spi.nss),
      .mosi      (mosi_s),
      .nss       (nss_s),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .nss_fall  (nss_fall)
   );

   assign rx_next = {rx_shift_reg[DATA_WIDTH-2:0], mosi_s};

   // Word to launch at the end of WAIT: a strobe arriving on that very clock still counts
   always_comb begin
      tx_word = MISSING_WORD;
      if (res_seen_reg) begin
         tx_word = result_reg;
      end else if (res_valid) begin
         tx_word = res;
      end
   end

   // Frame sequencer: receive op/A/B, publish them, wait, shift the result out
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg    <= IDLE;
         bit_cnt_reg  <= '0;
         rx_shift_reg <= '0;
         op_hold_reg  <= '0;
         a_hold_reg   <= '0;
         op_reg       <= '0;
         a_reg        <= '0;
         b_reg        <= '0;
         op_valid_reg <= 1'b0;
         result_reg   <= '0;
         res_seen_reg <= 1'b0;
         tx_shift_reg <= '0;
         miso_reg     <= 1'b0;
`ifdef SPI_OP_SLAVE_LATE_EN
         late_err_reg <= 1'b0;
`endif
      end else begin
         op_valid_reg <= 1'b0;
         if (state_reg != IDLE && nss_s) begin
            // Master deselected: abandon whatever was in flight
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            miso_reg    <= 1'b0;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (nss_fall) begin
                     state_reg    <= RX_OP;
                     bit_cnt_reg  <= '0;
                     result_reg   <= '0;
                     res_seen_reg <= 1'b0;
                  end
               end
               RX_OP: begin
                  if (sclk_fall) begin
                     rx_shift_reg <= rx_next;
                     if (bit_cnt_reg == OP_LAST) begin
                        op_hold_reg <= rx_next[OP_WIDTH-1:0];
                        bit_cnt_reg <= '0;
                        state_reg   <= RX_A;
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + CNT_ONE;
                     end
                  end
               end
               RX_A: begin
                  if (sclk_fall) begin
                     rx_shift_reg <= rx_next;
                     if (bit_cnt_reg == DATA_LAST) begin
                        a_hold_reg  <= rx_next;
                        bit_cnt_reg <= '0;
                        state_reg   <= RX_B;
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + CNT_ONE;
                     end
                  end
               end
               RX_B: begin
                  if (sclk_fall) begin
                     rx_shift_reg <= rx_next;
                     if (bit_cnt_reg == DATA_LAST) begin
                        op_reg       <= op_hold_reg;
                        a_reg        <= a_hold_reg;
                        b_reg        <= rx_next;
                        op_valid_reg <= 1'b1;
                        bit_cnt_reg  <= '0;
                        state_reg    <= WAIT;
`ifdef SPI_OP_SLAVE_LATE_EN
                        late_err_reg <= 1'b0;
`endif
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + CNT_ONE;
                     end
                  end
               end
               WAIT: begin
                  if (res_valid && !res_seen_reg) begin
                     result_reg   <= res;
                     res_seen_reg <= 1'b1;
                  end
                  if (sclk_rise) begin
                     if (bit_cnt_reg == WAIT_LAST) begin
                        miso_reg     <= tx_word[DATA_WIDTH-1];
                        tx_shift_reg <= {tx_word[DATA_WIDTH-2:0], 1'b0};
                        result_reg   <= tx_word;
                        res_seen_reg <= 1'b1;
                        bit_cnt_reg  <= '0;
                        state_reg    <= TX_RES;
`ifdef SPI_OP_SLAVE_LATE_EN
                        if (!res_seen_reg && !res_valid) begin
                           late_err_reg <= 1'b1;
                        end
`endif
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + CNT_ONE;
                     end
                  end
               end
               TX_RES: begin
                  if (sclk_rise) begin
                     miso_reg     <= tx_shift_reg[DATA_WIDTH-1];
                     tx_shift_reg <= {tx_shift_reg[DATA_WIDTH-2:0], 1'b0};
                  end
                  if (sclk_fall) begin
                     if (bit_cnt_reg == DATA_LAST) begin
                        miso_reg    <= 1'b0;
                        bit_cnt_reg <= '0;
                        state_reg   <= DONE;
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + CNT_ONE;
                     end
                  end
               end
               DONE: begin
                  // SCLK ignored; the deselect path above returns to IDLE
               end
               default: begin
                  state_reg <= IDLE;
               end
            endcase
         end
      end
   end

   assign op_valid = op_valid_reg;
   assign op       = op_reg;
   assign a        = a_reg;
   assign b        = b_reg;
   // Raw nss gates miso so the line drops immediately on deselect
   assign spi.miso = miso_reg & ~spi.nss;
`ifdef SPI_OP_SLAVE_LATE_EN
   assign late_err = late_err_reg;
`endif

endmodule
